// File: rtl/tone_pkg.sv
// tone_pkg: note encoding, nominal half-periods (in 50 MHz clocks) and the
// two reference melodies. Shared between the piezo driver and the tone
// decoder, so both ends of the sense loop use a single table.
package tone_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    G6   = 3'd1,
    C7   = 3'd2,
    E7   = 3'd3,
    G7   = 3'd4
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LISTEN,
    ST_EVAL
  } dec_state_t;

  localparam int unsigned NOM_G6 = 15945;
  localparam int unsigned NOM_C7 = 11945;
  localparam int unsigned NOM_E7 = 9481;
  localparam int unsigned NOM_G7 = 7972;

  localparam note_t BATT_SEQ    [3] = '{G6, C7, E7};
  localparam note_t FANFARE_SEQ [6] = '{G6, C7, E7, G7, E7, G7};

endpackage

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: sense-path bundle between the piezo loopback and the
// tone decoder.
//   tone_in      square wave from the sense path (async to clk)
//   note         current accepted note (tone_pkg::note_t)
//   note_vld     1-clk pulse on a new nonzero note
//   batt_low_det 1-clk pulse: melody was G6,C7,E7
//   fanfare_det  1-clk pulse: melody was G6,C7,E7,G7,E7,G7
//   seq_err      1-clk pulse: nonempty melody matching neither pattern
// master = decoder side, slave = source/observer side.
interface tone_decoder_if;
  logic            tone_in;
  tone_pkg::note_t note;
  logic            note_vld;
  logic            batt_low_det;
  logic            fanfare_det;
  logic            seq_err;

  modport master (
    input  tone_in,
    output note, note_vld, batt_low_det, fanfare_det, seq_err
  );

  modport slave (
    output tone_in,
    input  note, note_vld, batt_low_det, fanfare_det, seq_err
  );
endinterface

// File: rtl/tone_period_meas.sv
// tone_period_meas: synchronises tone_in, measures the clock count between
// edges and classifies each half-period against the four note windows.
//   clk, rst_n  clock, synchronous active-low reset
//   tone_i      raw square wave
//   cls_o       class of the half-period just ended (NONE if unmatched)
//   cls_vld_o   1-clk strobe, one per synchronised edge
//   sil_o       1-clk strobe when the counter saturates at SIL_CYC
module tone_period_meas
  import tone_pkg::*;
#(
  parameter int unsigned SIL_CYC   = 65536,
  parameter int unsigned TOL_SHIFT = 5,
  parameter int unsigned G6_HALF   = NOM_G6,
  parameter int unsigned C7_HALF   = NOM_C7,
  parameter int unsigned E7_HALF   = NOM_E7,
  parameter int unsigned G7_HALF   = NOM_G7
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tone_i,
  output note_t cls_o,
  output logic  cls_vld_o,
  output logic  sil_o
);

  localparam int unsigned   CNT_W   = $clog2(SIL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIL_CYC);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SIL_CYC - 1);

  // [0],[1] synchroniser, [2] delay flop for edge detection
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_w;
  note_t            cls_q, cls_d;
  logic             cls_vld_q, sil_q;

  function automatic logic in_win(input logic [CNT_W-1:0] h, input int unsigned nom);
    int unsigned hv, diff;
    hv   = 32'(h);
    diff = (hv > nom) ? hv - nom : nom - hv;
    return diff <= (nom >> TOL_SHIFT);
  endfunction

  assign edge_w = sync_q[1] ^ sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (edge_w)                cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // A count at or beyond the terminal value is either the first edge after
  // silence or an edge coincident with silence: both are discarded as NONE.
  always_comb begin
    cls_d = NONE;
    if (cnt_q < CNT_TC) begin
      if      (in_win(cnt_q, G6_HALF)) cls_d = G6;
      else if (in_win(cnt_q, C7_HALF)) cls_d = C7;
      else if (in_win(cnt_q, E7_HALF)) cls_d = E7;
      else if (in_win(cnt_q, G7_HALF)) cls_d = G7;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= CNT_MAX;
      cls_q     <= NONE;
      cls_vld_q <= 1'b0;
      sil_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], tone_i};
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      cls_vld_q <= edge_w;
      // Fires on the terminal count even if an edge lands in the same clock.
      sil_q     <= (cnt_q == CNT_TC);
    end
  end

  assign cls_o     = cls_q;
  assign cls_vld_o = cls_vld_q;
  assign sil_o     = sil_q;

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: turns classified half-periods into accepted notes, stores
// the note sequence and, on silence, reports which melody was heard.
//   clk, rst_n  clock, synchronous active-low reset
//   dec_if      tone_decoder_if.master (tone_in in; note/pulses out)
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned MIN_HALF  = 8,
  parameter int unsigned SIL_CYC   = 65536,
  parameter int unsigned TOL_SHIFT = 5,
  parameter int unsigned G6_HALF   = NOM_G6,
  parameter int unsigned C7_HALF   = NOM_C7,
  parameter int unsigned E7_HALF   = NOM_E7,
  parameter int unsigned G7_HALF   = NOM_G7
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_decoder_if.master dec_if
);

  localparam int unsigned      RUN_W   = $clog2(MIN_HALF + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_HALF);

  note_t            cls;
  logic             cls_vld, sil;
  dec_state_t       state_q;
  note_t            prev_q, note_q;
  logic [RUN_W-1:0] run_q, run_nx;
  note_t            store_q [6];
  logic [2:0]       len_q;
  logic             ovf_q, pend_q;
  logic             note_vld_q, batt_q, fan_q, err_q;
  logic             accept, batt_m, fan_m;

  tone_period_meas #(
    .SIL_CYC  (SIL_CYC),
    .TOL_SHIFT(TOL_SHIFT),
    .G6_HALF  (G6_HALF),
    .C7_HALF  (C7_HALF),
    .E7_HALF  (E7_HALF),
    .G7_HALF  (G7_HALF)
  ) u_meas (
    .clk      (clk),
    .rst_n    (rst_n),
    .tone_i   (dec_if.tone_in),
    .cls_o    (cls),
    .cls_vld_o(cls_vld),
    .sil_o    (sil)
  );

  // Run length saturates at MIN_HALF; acceptance is then gated by class != note,
  // so a long run of the current note never re-appends.
  always_comb begin
    run_nx = '0;
    if (cls != NONE) begin
      if (cls != prev_q)        run_nx = RUN_W'(1);
      else if (run_q < RUN_MAX) run_nx = run_q + 1'b1;
      else                      run_nx = run_q;
    end
    accept = (state_q == ST_LISTEN) && cls_vld && !sil &&
             (run_nx == RUN_MAX) && (cls != note_q);
  end

  always_comb begin
    batt_m = (len_q == 3'd3);
    for (int unsigned i = 0; i < 3; i++)
      if (store_q[i] != BATT_SEQ[i]) batt_m = 1'b0;
    fan_m = (len_q == 3'd6);
    for (int unsigned i = 0; i < 6; i++)
      if (store_q[i] != FANFARE_SEQ[i]) fan_m = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prev_q     <= NONE;
      note_q     <= NONE;
      run_q      <= '0;
      store_q    <= '{default: NONE};
      len_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      note_vld_q <= 1'b0;
      batt_q     <= 1'b0;
      fan_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      note_vld_q <= 1'b0;
      batt_q     <= 1'b0;
      fan_q      <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cls_vld || pend_q) begin
            state_q <= ST_LISTEN;
            pend_q  <= 1'b0;
          end
        end
        ST_LISTEN: begin
          if (sil) begin
            // An edge coincident with silence opens the next melody after EVAL.
            state_q <= ST_EVAL;
            pend_q  <= cls_vld;
          end else if (cls_vld) begin
            prev_q <= cls;
            run_q  <= run_nx;
            if (accept) begin
              note_q     <= cls;
              note_vld_q <= 1'b1;
              if (len_q < 3'd6) begin
                store_q[len_q] <= cls;
                len_q          <= len_q + 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
        end
        ST_EVAL: begin
          if (ovf_q) begin
            err_q <= 1'b1;
          end else if (len_q != 3'd0) begin
            batt_q <= batt_m;
            fan_q  <= fan_m;
            err_q  <= !batt_m && !fan_m;
          end
          store_q <= '{default: NONE};
          len_q   <= '0;
          ovf_q   <= 1'b0;
          note_q  <= NONE;
          prev_q  <= NONE;
          run_q   <= '0;
          if (cls_vld) pend_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dec_if.note         = note_q;
  assign dec_if.note_vld     = note_vld_q;
  assign dec_if.batt_low_det = batt_q;
  assign dec_if.fanfare_det  = fan_q;
  assign dec_if.seq_err      = err_q;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed melodies on a scaled-down tone table, checked
// every clock against a note/melody model kept in the bench.
module tb_tone_decoder;
  import tone_pkg::*;

  localparam int MIN_HALF = 8;
  localparam int SIL      = 600;
  localparam int TOL      = 5;
  localparam int H_G6 = 160, H_C7 = 120, H_E7 = 95, H_G7 = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tone_decoder_if dif ();

  tone_decoder #(
    .MIN_HALF (MIN_HALF),
    .SIL_CYC  (SIL),
    .TOL_SHIFT(TOL),
    .G6_HALF  (H_G6),
    .C7_HALF  (H_C7),
    .E7_HALF  (H_E7),
    .G7_HALF  (H_G7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec_if(dif)
  );

  always #10 clk = ~clk;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // expected-event schedule, keyed by cycle number
  bit exp_vld  [int];
  int exp_det  [int];   // 1 batt, 2 fanfare, 3 seq_err
  int note_chg [int];
  int exp_note = 0;

  // melody model
  int nom [4] = '{H_G6, H_C7, H_E7, H_G7};
  int q_cls[$];
  int acc[$];
  int cur_note  = 0;
  int last_t    = 0;
  bit have_last = 1'b0;
  int batt_ref[$] = '{1, 2, 3};
  int fan_ref[$]  = '{1, 2, 3, 4, 3, 4};

  // observed DUT activity
  int n_vld = 0, n_batt = 0, n_fan = 0, n_err = 0;
  int batt_cyc = 0;
  int seen[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int classify(input int h);
    int d;
    for (int i = 0; i < 4; i++) begin
      d = (h > nom[i]) ? h - nom[i] : nom[i] - h;
      if (d <= (nom[i] >>> TOL)) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit acc_is(input int r[$]);
    if (acc.size() != r.size()) return 1'b0;
    foreach (r[i]) if (acc[i] != r[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int seen_at(input int i);
    return (i < seen.size()) ? seen[i] : -1;
  endfunction

  // A note is accepted when the last MIN_HALF half-periods all fall in one
  // note window and that note is not already the current one.
  task automatic model_edge(input int t);
    int c;
    bit same;
    c = have_last ? classify(t - last_t) : 0;
    have_last = 1'b1;
    last_t    = t;
    q_cls.push_back(c);
    if (c != 0 && c != cur_note && q_cls.size() >= MIN_HALF) begin
      same = 1'b1;
      for (int k = q_cls.size() - MIN_HALF; k < q_cls.size(); k++)
        if (q_cls[k] != c) same = 1'b0;
      if (same) begin
        cur_note = c;
        acc.push_back(c);
        exp_vld[t + 4]  = 1'b1;
        note_chg[t + 4] = c;
      end
    end
  endtask

  task automatic model_clear();
    q_cls.delete();
    acc.delete();
    cur_note  = 0;
    have_last = 1'b0;
  endtask

  task automatic model_silence();
    int k;
    int t;
    t = last_t + SIL + 4;
    if (acc.size() == 0)   k = 0;
    else if (acc.size() > 6) k = 3;
    else if (acc_is(batt_ref)) k = 1;
    else if (acc_is(fan_ref))  k = 2;
    else k = 3;
    if (k != 0) exp_det[t] = k;
    note_chg[t] = 0;
    model_clear();
  endtask

  task automatic toggle();
    dif.tone_in = ~dif.tone_in;
    model_edge(cyc);
  endtask

  task automatic start();
    @(negedge clk);
    toggle();
  endtask

  task automatic hp(input int len, input int n);
    repeat (n) begin
      repeat (len) @(negedge clk);
      toggle();
    end
  endtask

  task automatic silence();
    model_silence();
    repeat (SIL + 20) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_vld.delete();
    exp_det.delete();
    note_chg.delete();
    note_chg[cyc + 1] = 0;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      dif.tone_in = ~dif.tone_in;
    end
    @(negedge clk);
    rst_n       = 1'b1;
    dif.tone_in = 1'b0;
  endtask

  task automatic clear_obs();
    n_vld = 0; n_batt = 0; n_fan = 0; n_err = 0;
    seen.delete();
  endtask

  // per-cycle compare against the schedule
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (note_chg.exists(cyc)) exp_note = note_chg[cyc];
      chk("note",         int'(dif.note),         exp_note);
      chk("note_vld",     int'(dif.note_vld),     int'(exp_vld.exists(cyc)));
      chk("batt_low_det", int'(dif.batt_low_det), int'(exp_det.exists(cyc) && exp_det[cyc] == 1));
      chk("fanfare_det",  int'(dif.fanfare_det),  int'(exp_det.exists(cyc) && exp_det[cyc] == 2));
      chk("seq_err",      int'(dif.seq_err),      int'(exp_det.exists(cyc) && exp_det[cyc] == 3));
      if (dif.note_vld === 1'b1) begin n_vld++; seen.push_back(int'(dif.note)); end
      if (dif.batt_low_det === 1'b1) begin n_batt++; batt_cyc = cyc; end
      if (dif.fanfare_det === 1'b1) n_fan++;
      if (dif.seq_err === 1'b1) n_err++;
    end
  end

  initial begin
    int t_last;
    dif.tone_in = 1'b0;

    // pin the model's note windows
    chk("model_cls_120", classify(120), 2);
    chk("model_cls_165", classify(165), 1);
    chk("model_cls_98",  classify(98),  0);
    chk("model_cls_78",  classify(78),  4);

    // reset with tone_in toggling
    repeat (3) begin
      @(negedge clk);
      dif.tone_in = ~dif.tone_in;
    end
    @(negedge clk);
    rst_n       = 1'b1;
    dif.tone_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_no_pulses", n_vld + n_batt + n_fan + n_err, 0);

    // battery-low jingle
    clear_obs();
    start();
    hp(H_G6, 10); hp(H_C7, 10); hp(H_E7, 12);
    t_last = last_t;
    silence();
    chk("jingle_vld_count", n_vld, 3);
    chk("jingle_note0", seen_at(0), 1);
    chk("jingle_note1", seen_at(1), 2);
    chk("jingle_note2", seen_at(2), 3);
    chk("jingle_batt_count", n_batt, 1);
    chk("jingle_batt_latency", batt_cyc - t_last, SIL + 4);
    chk("jingle_other_det", n_fan + n_err, 0);

    // fanfare
    clear_obs();
    start();
    hp(H_G6, 10); hp(H_C7, 10); hp(H_E7, 10);
    hp(H_G7, 10); hp(H_E7, 10); hp(H_G7, 10);
    silence();
    chk("fanfare_vld_count", n_vld, 6);
    chk("fanfare_note3", seen_at(3), 4);
    chk("fanfare_note5", seen_at(5), 4);
    chk("fanfare_det_count", n_fan, 1);
    chk("fanfare_other_det", n_batt + n_err, 0);

    // tolerance: edge of the G6 window is accepted
    clear_obs();
    start();
    hp(165, 10);
    silence();
    chk("tol_in_vld", n_vld, 1);
    chk("tol_in_note", seen_at(0), 1);
    chk("tol_in_err", n_err, 1);

    // tolerance: just outside the E7 window, nothing at all
    clear_obs();
    start();
    hp(98, 12);
    silence();
    chk("tol_out_vld", n_vld, 0);
    chk("tol_out_det", n_batt + n_fan + n_err, 0);

    // glitch: short C7 burst inside G6
    clear_obs();
    start();
    hp(H_G6, 10); hp(H_C7, 5); hp(H_G6, 10);
    chk("glitch_note_held", int'(dif.note), 1);
    silence();
    chk("glitch_vld", n_vld, 1);
    chk("glitch_err", n_err, 1);

    // seven notes overflow the store
    clear_obs();
    start();
    hp(H_G6, 10); hp(H_C7, 10); hp(H_E7, 10); hp(H_G7, 10);
    hp(H_E7, 10); hp(H_G7, 10); hp(H_C7, 10);
    silence();
    chk("seven_vld", n_vld, 7);
    chk("seven_err", n_err, 1);
    chk("seven_other_det", n_batt + n_fan, 0);

    // reset mid-melody, then E7 only
    clear_obs();
    start();
    hp(H_G6, 10); hp(H_C7, 10);
    do_reset();
    start();
    hp(H_E7, 12);
    silence();
    chk("rst_mid_vld", n_vld, 3);
    chk("rst_mid_last_note", seen_at(2), 3);
    chk("rst_mid_err", n_err, 1);
    chk("rst_mid_other_det", n_batt + n_fan, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
